// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, frame sync bytes,
// sticky error codes and core opcodes so frames can be built symbolically.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DHI,
        S_DLO,
        S_WR,
        S_CSUM
    } state_t;

    localparam logic [7:0] SYNC_IMEM_DEF = 8'hA5;
    localparam logic [7:0] SYNC_DMEM_DEF = 8'h5A;
    localparam logic [7:0] SYNC_GO_DEF   = 8'hC3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_COUNT   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [3:0] ADD  = 4'h1;
    localparam logic [3:0] SUB  = 4'h2;
    localparam logic [3:0] LOAD = 4'h3;

    // A frame may write at most the whole memory once.
    function automatic logic count_bad(input logic [7:0] cnt, input int addr_w);
        return (cnt == 8'd0) || ({1'b0, cnt} > 9'(1 << addr_w));
    endfunction

endpackage

// File: rtl/program_loader_timeout.sv
// Inter-byte idle counter: cleared on each accepted byte, counts while enabled,
// holds at LIMIT and flags expired; LIMIT of 0 never expires.
module loader_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    assign expired = (LIMIT != 0) && (cnt == LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Framed byte stream -> imem/dmem write strobes; holds the core until a GO byte.
// Write strobe one cycle after a word's last byte; in_ready drops only during that write cycle.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         IADDR_W   = 4,
    parameter int         DADDR_W   = 4,
    parameter logic [7:0] SYNC_IMEM = SYNC_IMEM_DEF,
    parameter logic [7:0] SYNC_DMEM = SYNC_DMEM_DEF,
    parameter logic [7:0] SYNC_GO   = SYNC_GO_DEF,
    parameter int         TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [15:0]        imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [7:0]         dmem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    state_t     state, state_nxt;
    logic       is_dmem;
    logic [7:0] addr_q, count_q, sum_q, hi_q, lo_q;
    logic [7:0] sum_nxt;
    logic [1:0] err_nxt;
    logic       done_nxt, hold_nxt;
    logic       xfer, expired;

    assign xfer    = in_valid && in_ready;
    assign sum_nxt = sum_q + in_data;
    assign busy    = (state != S_IDLE);

    assign imem_we    = (state == S_WR) && !is_dmem;
    assign dmem_we    = (state == S_WR) && is_dmem;
    assign imem_addr  = addr_q[IADDR_W-1:0];
    assign dmem_addr  = addr_q[DADDR_W-1:0];
    assign imem_wdata = {hi_q, lo_q};
    assign dmem_wdata = hi_q;

    loader_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (xfer || !busy),
        .enable  (busy),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = (state != S_WR);
        err_nxt   = err;
        done_nxt  = 1'b0;
        hold_nxt  = cpu_hold;
        case (state)
            S_IDLE: if (in_valid) begin
                if (in_data == SYNC_IMEM || in_data == SYNC_DMEM) begin
                    state_nxt = S_ADDR;
                    hold_nxt  = 1'b1;
                    err_nxt   = ERR_NONE;
                end else if (in_data == SYNC_GO) begin
                    hold_nxt = 1'b0;
                end
            end
            S_ADDR:  if (xfer) state_nxt = S_COUNT;
            S_COUNT: if (xfer) begin
                if (count_bad(in_data, is_dmem ? DADDR_W : IADDR_W)) begin
                    state_nxt = S_IDLE;
                    err_nxt   = ERR_COUNT;
                end else begin
                    state_nxt = S_DHI;
                end
            end
            S_DHI:   if (xfer) state_nxt = is_dmem ? S_WR : S_DLO;
            S_DLO:   if (xfer) state_nxt = S_WR;
            S_WR:    state_nxt = (count_q == 8'd1) ? S_CSUM : S_DHI;
            S_CSUM:  if (xfer) begin
                state_nxt = S_IDLE;
                if (sum_nxt == 8'd0) done_nxt = 1'b1;
                else                 err_nxt  = ERR_CSUM;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A byte arriving on the expiry cycle still counts; the write cycle is never aborted.
        if (busy && state != S_WR && !xfer && expired) begin
            state_nxt = S_IDLE;
            err_nxt   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            is_dmem  <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            err      <= ERR_NONE;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            state    <= state_nxt;
            err      <= err_nxt;
            done     <= done_nxt;
            cpu_hold <= hold_nxt;
            if (state == S_WR) begin
                addr_q  <= addr_q + 8'd1;
                count_q <= count_q - 8'd1;
            end
            if (xfer) begin
                sum_q <= sum_nxt;
                case (state)
                    S_IDLE: begin
                        is_dmem <= (in_data == SYNC_DMEM);
                        sum_q   <= '0;
                    end
                    S_ADDR:  addr_q  <= in_data;
                    S_COUNT: count_q <= in_data;
                    S_DHI:   hi_q    <= in_data;
                    S_DLO:   lo_q    <= in_data;
                    default: ;
                endcase
            end
        end
    end

endmodule
